// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM encoding and helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    localparam int ArbStateWidth = 3;

    typedef enum logic [ArbStateWidth-1:0] {
        ArbIdle  = 3'd0,
        ArbAccI  = 3'd1,
        ArbAccD  = 3'd2,
        ArbRespI = 3'd3,
        ArbRespD = 3'd4
    } arb_state_t;

    // Instruction fetches always read a whole word.
    localparam logic [3:0] FullWordSlct = 4'b1111;

    // Wait counter width; a latency below 1 is illegal, so clamp to a sane width.
    function automatic int wait_cnt_width(input int latency);
        return (latency < 1) ? 1 : $clog2(latency + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between the fetch port and the data port; data wins ties.
// Latency: request seen in IDLE at cycle 0 -> ready pulse in cycle MemLatency+1; one access per MemLatency+2 cycles.
// Backpressure: stall_req is held while any request is pending; requesters hold operands through their ready cycle.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   i_req/i_addr             fetch request in;  i_rdata/i_ready fetch response out
//   d_re/d_we/d_addr/...     data request in;   d_rdata/d_ready data response out
//   stall_req                to hazard control
//   mem_*                    single-port memory interface (mem_rdata is combinational while mem_ce=1)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MemLatency = 1,
    parameter int AddrWidth  = 32,
    parameter int DataWidth  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_req,
    input  logic [AddrWidth-1:0] i_addr,
    output logic [DataWidth-1:0] i_rdata,
    output logic                 i_ready,
    input  logic                 d_re,
    input  logic                 d_we,
    input  logic [AddrWidth-1:0] d_addr,
    input  logic [3:0]           d_byte_slct,
    input  logic [DataWidth-1:0] d_wdata,
    output logic [DataWidth-1:0] d_rdata,
    output logic                 d_ready,
    output logic                 stall_req,
    output logic                 mem_ce,
    output logic                 mem_we,
    output logic [AddrWidth-1:0] mem_addr,
    output logic [3:0]           mem_byte_slct,
    output logic [DataWidth-1:0] mem_wdata,
    input  logic [DataWidth-1:0] mem_rdata
);

    localparam int                  CntWidth = wait_cnt_width(MemLatency);
    localparam logic [CntWidth-1:0] LastCnt  = CntWidth'(MemLatency - 1);

    arb_state_t           state;
    arb_state_t           state_nxt;
    logic [CntWidth-1:0]  cnt;
    logic                 d_req;
    logic                 last_cyc;

    // Request registers: the memory side is driven only from these, so
    // requester operand changes mid-access cannot leak onto the bus.
    logic [AddrWidth-1:0] req_addr;
    logic [3:0]           req_byte_slct;
    logic [DataWidth-1:0] req_wdata;
    logic                 req_we;
    logic [DataWidth-1:0] resp_i;
    logic [DataWidth-1:0] resp_d;

    assign d_req    = d_re | d_we;
    assign last_cyc = (cnt == LastCnt);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ArbIdle;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; data has fixed priority because the MEM-stage
    // instruction is older than the one being fetched.
    always_comb begin
        state_nxt = state;
        case (state)
            ArbIdle: begin
                if (d_req) begin
                    state_nxt = ArbAccD;
                end else if (i_req) begin
                    state_nxt = ArbAccI;
                end
            end
            ArbAccI:  if (last_cyc) state_nxt = ArbRespI;
            ArbAccD:  if (last_cyc) state_nxt = ArbRespD;
            ArbRespI: state_nxt = ArbIdle;
            ArbRespD: state_nxt = ArbIdle;
            default:  state_nxt = ArbIdle;
        endcase
    end

    // Wait counter, grant-time request latch and response capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt           <= '0;
            req_addr      <= '0;
            req_byte_slct <= '0;
            req_wdata     <= '0;
            req_we        <= 1'b0;
            resp_i        <= '0;
            resp_d        <= '0;
        end else begin
            case (state)
                ArbIdle: begin
                    if (d_req) begin
                        req_addr      <= d_addr;
                        req_byte_slct <= d_byte_slct;
                        req_wdata     <= d_wdata;
                        req_we        <= d_we;   // re&we together is a write
                    end else if (i_req) begin
                        req_addr      <= i_addr;
                        req_byte_slct <= FullWordSlct;
                        req_wdata     <= '0;
                        req_we        <= 1'b0;
                    end
                end
                ArbAccI, ArbAccD: begin
                    if (last_cyc) begin
                        cnt <= '0;
                        if (state == ArbAccI) begin
                            resp_i <= mem_rdata;
                        end else begin
                            resp_d <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt + CntWidth'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output logic
    always_comb begin
        mem_ce        = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_byte_slct = '0;
        mem_wdata     = '0;
        i_ready       = 1'b0;
        d_ready       = 1'b0;
        case (state)
            ArbAccI, ArbAccD: begin
                mem_ce        = 1'b1;
                mem_we        = (state == ArbAccD) & req_we;
                mem_addr      = req_addr;
                mem_byte_slct = req_byte_slct;
                mem_wdata     = req_wdata;
            end
            ArbRespI: i_ready = 1'b1;
            ArbRespD: d_ready = 1'b1;
            default: begin
            end
        endcase
        i_rdata   = resp_i;
        d_rdata   = resp_d;
        stall_req = ~rst & ((i_req & ~i_ready) | (d_req & ~d_ready));
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a MemLatency=3 instance with a word memory and
// a MemLatency=1 instance for the single-fetch timing case.
// Reference: ref_mem tracks expected memory contents; timing expectations come from MemLatency.
module tb_mem_arbiter;

    localparam int ML = 3;

    logic        clk = 1'b0;
    logic        rst;
    always #5 clk = ~clk;

    // MemLatency = ML instance
    logic        i_req, i_ready, d_re, d_we, d_ready, stall_req, mem_ce, mem_we;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  d_byte_slct, mem_byte_slct;

    // MemLatency = 1 instance
    logic        s1_i_req, s1_i_ready, s1_d_re, s1_d_we, s1_d_ready, s1_stall, s1_mem_ce, s1_mem_we;
    logic [31:0] s1_i_addr, s1_i_rdata, s1_d_addr, s1_d_wdata, s1_d_rdata;
    logic [31:0] s1_mem_addr, s1_mem_wdata, s1_mem_rdata;
    logic [3:0]  s1_d_byte_slct, s1_mem_byte_slct;

    mem_arbiter #(.MemLatency(ML), .AddrWidth(32), .DataWidth(32)) u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_byte_slct(d_byte_slct),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_ready(d_ready),
        .stall_req(stall_req),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_byte_slct(mem_byte_slct), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.MemLatency(1), .AddrWidth(32), .DataWidth(32)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_req(s1_i_req), .i_addr(s1_i_addr), .i_rdata(s1_i_rdata), .i_ready(s1_i_ready),
        .d_re(s1_d_re), .d_we(s1_d_we), .d_addr(s1_d_addr), .d_byte_slct(s1_d_byte_slct),
        .d_wdata(s1_d_wdata), .d_rdata(s1_d_rdata), .d_ready(s1_d_ready),
        .stall_req(s1_stall),
        .mem_ce(s1_mem_ce), .mem_we(s1_mem_we), .mem_addr(s1_mem_addr),
        .mem_byte_slct(s1_mem_byte_slct), .mem_wdata(s1_mem_wdata), .mem_rdata(s1_mem_rdata)
    );

    // Memory models
    logic [31:0] mem     [0:127];
    logic [31:0] ref_mem [0:127];
    logic        do_init;

    function automatic logic [31:0] init_word(input int i);
        return 32'h1100_0000 + 32'(i) * 32'h0001_0203;
    endfunction

    assign mem_rdata    = mem_ce ? mem[mem_addr[8:2]] : 32'h0;
    assign s1_mem_rdata = s1_mem_ce ? ((s1_mem_addr == 32'h4) ? 32'h3401_0001 : 32'hDEAD_BEEF) : 32'h0;

    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_word(i);
        end else if (mem_ce && mem_we) begin
            for (int b = 0; b < 4; b++)
                if (mem_byte_slct[b]) mem[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; port 0 = fetch, 1 = data. Called just after a rising edge.
    task automatic txn(input int port, input bit re, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] bs, output logic [31:0] got);
        int ready_k, ce_n, we_n, stall_n, bad_addr, bad_bs, bad_other;
        bit is_write;
        logic [3:0] exp_bs;
        ready_k = -1; ce_n = 0; we_n = 0; stall_n = 0; bad_addr = 0; bad_bs = 0; bad_other = 0;
        got = 32'h0;
        is_write = (port == 1) && we;
        exp_bs   = (port == 0) ? 4'hF : bs;
        if (port == 0) begin
            i_req = 1'b1; i_addr = addr;
        end else begin
            d_re = re; d_we = we; d_addr = addr; d_byte_slct = bs; d_wdata = wdata;
        end
        for (int k = 0; k < 40 && ready_k < 0; k++) begin
            @(negedge clk);
            if (mem_ce) begin
                ce_n++;
                if (mem_we) we_n++;
                if (mem_addr !== addr) bad_addr++;
                if (mem_byte_slct !== exp_bs) bad_bs++;
            end
            if (stall_req) stall_n++;
            if ((port == 0) ? d_ready : i_ready) bad_other++;
            if ((port == 0) ? i_ready : d_ready) begin
                ready_k = k;
                got = (port == 0) ? i_rdata : d_rdata;
            end
            next_cycle();
        end
        i_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
        check("txn_latency", 32'(ready_k), 32'(ML + 1));
        check("txn_ce_cycles", 32'(ce_n), 32'(ML));
        check("txn_we_cycles", 32'(we_n), is_write ? 32'(ML) : 32'h0);
        check("txn_stall_cycles", 32'(stall_n), 32'(ML + 1));
        check("txn_addr_stable", 32'(bad_addr), 32'h0);
        check("txn_byte_slct", 32'(bad_bs), 32'h0);
        check("txn_other_ready", 32'(bad_other), 32'h0);
        if (is_write) begin
            for (int b = 0; b < 4; b++)
                if (bs[b]) ref_mem[addr[8:2]][8*b +: 8] = wdata[8*b +: 8];
        end else begin
            check("txn_rdata", got, ref_mem[addr[8:2]]);
        end
    endtask

    typedef struct {
        int          port;
        bit          re;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  bs;
        bit          chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [31:0] got;
        int d_k, i_k, stall_n, first_addr_bad, second_addr_bad, ce_n, rdy_n;
        logic [31:0] d_got, i_got;

        tbl[0] = '{1, 1'b0, 1'b1, 32'h20, 32'h0000_AB00, 4'b0010, 1'b0, 32'h0};
        tbl[1] = '{1, 1'b1, 1'b0, 32'h20, 32'h0,         4'b1111, 1'b1, 32'h1108_AB18};
        tbl[2] = '{0, 1'b0, 1'b0, 32'h20, 32'h0,         4'b1111, 1'b1, 32'h1108_AB18};
        tbl[3] = '{1, 1'b1, 1'b1, 32'h24, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0};
        tbl[4] = '{0, 1'b0, 1'b0, 32'h24, 32'h0,         4'b1111, 1'b1, 32'hCAFE_F00D};
        tbl[5] = '{1, 1'b1, 1'b0, 32'h04, 32'h0,         4'b1111, 1'b1, 32'h1101_0203};

        rst = 1'b1; do_init = 1'b1;
        i_req = 0; i_addr = 0; d_re = 0; d_we = 0; d_addr = 0; d_byte_slct = 0; d_wdata = 0;
        s1_i_req = 0; s1_i_addr = 0; s1_d_re = 0; s1_d_we = 0; s1_d_addr = 0;
        s1_d_byte_slct = 0; s1_d_wdata = 0;
        for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);
        repeat (3) next_cycle();
        do_init = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_mem_ce", {31'b0, mem_ce}, 32'h0);
        check("rst_mem_we", {31'b0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_ready", {30'b0, i_ready, d_ready}, 32'h0);
        check("rst_stall", {31'b0, stall_req}, 32'h0);
        check("rst_rdata", i_rdata | d_rdata, 32'h0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        // Single fetch on the MemLatency=1 instance
        s1_i_req = 1'b1; s1_i_addr = 32'h4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("ml1_ce_c%0d", k), {31'b0, s1_mem_ce}, (k == 1) ? 32'h1 : 32'h0);
            check($sformatf("ml1_ready_c%0d", k), {31'b0, s1_i_ready}, (k == 2) ? 32'h1 : 32'h0);
            check($sformatf("ml1_stall_c%0d", k), {31'b0, s1_stall}, (k <= 1) ? 32'h1 : 32'h0);
            if (k == 1) check("ml1_addr", s1_mem_addr, 32'h4);
            if (k == 2) check("ml1_rdata", s1_i_rdata, 32'h3401_0001);
            next_cycle();
            if (k == 2) s1_i_req = 1'b0;
        end

        // Table vectors
        foreach (tbl[n]) begin
            txn(tbl[n].port, tbl[n].re, tbl[n].we, tbl[n].addr, tbl[n].wdata, tbl[n].bs, got);
            if (tbl[n].chk_rd) check($sformatf("tbl%0d_rdata", n), got, tbl[n].exp_rd);
            next_cycle();
        end

        // Simultaneous fetch and data read: data first, fetch on the following IDLE
        d_k = -1; i_k = -1; stall_n = 0; first_addr_bad = 0; second_addr_bad = 0; ce_n = 0;
        d_got = 0; i_got = 0;
        i_req = 1'b1; i_addr = 32'h8; d_re = 1'b1; d_addr = 32'h100; d_byte_slct = 4'hF;
        for (int k = 0; k < 40 && i_k < 0; k++) begin
            @(negedge clk);
            if (stall_req) stall_n++;
            if (mem_ce) begin
                ce_n++;
                if (d_k < 0 && mem_addr !== 32'h100) first_addr_bad++;
                if (d_k >= 0 && mem_addr !== 32'h8) second_addr_bad++;
            end
            if (d_ready) begin d_k = k; d_got = d_rdata; end
            if (i_ready) begin i_k = k; i_got = i_rdata; end
            next_cycle();
            if (d_ready || d_k == k) d_re = 1'b0;
        end
        i_req = 1'b0;
        check("sim_d_ready_cycle", 32'(d_k), 32'(ML + 1));
        check("sim_i_ready_cycle", 32'(i_k), 32'(2 * ML + 3));
        check("sim_ce_cycles", 32'(ce_n), 32'(2 * ML));
        check("sim_addr_data_first", 32'(first_addr_bad), 32'h0);
        check("sim_addr_fetch_second", 32'(second_addr_bad), 32'h0);
        check("sim_stall_cycles", 32'(stall_n), 32'(2 * ML + 3));
        check("sim_d_rdata", d_got, ref_mem[64]);
        check("sim_i_rdata", i_got, ref_mem[2]);
        next_cycle();

        // Operand change mid-access must not reach the memory bus
        d_k = -1; first_addr_bad = 0; d_got = 0;
        d_re = 1'b1; d_addr = 32'h40; d_byte_slct = 4'hF;
        for (int k = 0; k < 40 && d_k < 0; k++) begin
            @(negedge clk);
            if (mem_ce && mem_addr !== 32'h40) first_addr_bad++;
            if (d_ready) begin d_k = k; d_got = d_rdata; end
            next_cycle();
            if (k == 1) d_addr = 32'h80;
        end
        d_re = 1'b0;
        check("opchg_addr_held", 32'(first_addr_bad), 32'h0);
        check("opchg_ready_cycle", 32'(d_k), 32'(ML + 1));
        check("opchg_rdata", d_got, ref_mem[16]);
        next_cycle();

        // Reset in the second access cycle of a write aborts it with no ready pulse
        rdy_n = 0;
        d_we = 1'b1; d_addr = 32'h190; d_byte_slct = 4'hF; d_wdata = 32'h55AA_55AA;
        next_cycle();                       // cycle 1: first access cycle
        next_cycle();                       // cycle 2: second access cycle
        rst = 1'b1;
        @(negedge clk);
        check("rstw_stall_in_rst", {31'b0, stall_req}, 32'h0);
        if (d_ready) rdy_n++;
        next_cycle();
        @(negedge clk);
        check("rstw_mem_ce", {31'b0, mem_ce}, 32'h0);
        check("rstw_mem_we", {31'b0, mem_we}, 32'h0);
        if (d_ready) rdy_n++;
        next_cycle();
        rst = 1'b0; d_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (d_ready || mem_ce) rdy_n++;
            next_cycle();
        end
        check("rstw_no_ready", 32'(rdy_n), 32'h0);
        txn(0, 1'b0, 1'b0, 32'h4, 32'h0, 4'hF, got);
        check("rstw_fetch_after", got, init_word(1));
        next_cycle();

        // Randomized traffic against the reference memory
        for (int n = 0; n < 40; n++) begin
            int port, op;
            logic [31:0] addr, wdata;
            logic [3:0]  bs;
            port  = int'($urandom_range(0, 1));
            op    = int'($urandom_range(0, 2));
            addr  = {23'b0, 7'($urandom_range(0, 31)), 2'b00};
            wdata = $urandom;
            bs    = 4'($urandom_range(1, 15));
            if (port == 0)
                txn(0, 1'b0, 1'b0, addr, 32'h0, 4'hF, got);
            else
                txn(1, op != 1, op != 0, addr, wdata, bs, got);
            repeat ($urandom_range(0, 2)) next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port unified memory between the CPU instruction-fetch port and the CPU data port.
- Sits between pipeline_CPU and the memory model in the SOPC. It replaces the separate ROM and RAM paths.
- Grants one requester at a time, holds the memory access for a configurable number of wait cycles, and returns the read data with a one-cycle ready pulse.
- Raises a stall request toward the pipeline while any accepted request is outstanding.

Parameters:
- MemLatency, 1, cycles mem_ce is held per access; must be >= 1.
- AddrWidth, `MemAddrWidth (32), address width on every port.
- DataWidth, `RegDataWidth (32), data width on every port.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high (`RstEnable).
- i_req  in  1  instruction fetch request (CPU rom_ce).
- i_addr  in  AddrWidth  fetch address.
- i_rdata  out  DataWidth  fetched instruction; valid only while i_ready=1.
- i_ready  out  1  one-cycle completion pulse for the fetch port.
- d_re  in  1  data read request.
- d_we  in  1  data write request.
- d_addr  in  AddrWidth  data address.
- d_byte_slct  in  4  byte lane enables.
- d_wdata  in  DataWidth  write data.
- d_rdata  out  DataWidth  load data; valid only while d_ready=1.
- d_ready  out  1  one-cycle completion pulse for the data port.
- stall_req  out  1  to HazardControl; high while a request is pending and not yet completed.
- mem_ce  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  AddrWidth  memory address.
- mem_byte_slct  out  4  byte enables to memory.
- mem_wdata  out  DataWidth  write data to memory.
- mem_rdata  in  DataWidth  memory read data; valid combinationally while mem_ce=1.

Behaviour:
- States: IDLE, ACC_I, ACC_D, RESP_I, RESP_D. A wait counter is sized clog2(MemLatency+1).
- Reset values: state=IDLE, counter=0. All outputs 0, including i_rdata/d_rdata (their latches are cleared).
- IDLE, arbitration:
  - d_req = d_re | d_we.
  - If d_req, go to ACC_D. Data has fixed priority because the MEM-stage instruction is older.
  - Else if i_req, go to ACC_I. Else stay in IDLE.
- Grant-time latching: on the grant edge, latch addr, byte_slct, wdata and we into request registers.
  - The fetch port latches byte_slct=4'b1111 and we=0.
  - The memory side is driven only from these registers, never directly from the requester inputs.
  - If d_re and d_we are both 1, the access is a write.
- ACC_x:
  - mem_ce=1. mem_we = latched we, asserted only in ACC_D.
  - The counter increments each cycle. The state holds for exactly MemLatency cycles.
  - On the last cycle's edge, latch mem_rdata into the response register, clear the counter and go to RESP_x.
- RESP_x:
  - x_ready=1 for exactly one cycle. x_rdata = response register. mem_ce=0.
  - Next state is IDLE. There is no arbitration in RESP.
- Latency: request seen in IDLE at cycle 0 gives ready in cycle MemLatency+1. Back-to-back throughput is one access per MemLatency+2 cycles.
- Requester contract:
  - Hold req and its operands stable through the ready cycle inclusive.
  - A request still asserted in the cycle after ready is a new request.
- stall_req = (i_req & ~i_ready) | (d_req & ~d_ready). It is combinational, low during reset, and low in IDLE with no requests.
- Simultaneous i_req and d_req in IDLE: data is served first. Fetch is served on the next IDLE, and i_req stays stalled meanwhile.
- Starvation: none in practice, because the pipeline freezes on stall_req. No fairness logic is required.
- Reset mid-access: the state returns to IDLE at the next edge and all memory outputs drop. A write interrupted while mem_we=1 may have been committed. No ready pulse is issued for an aborted access.
- Reads never assert mem_we. Writes return d_rdata = whatever mem_rdata was on the last access cycle; the requester ignores it.

Decomposition:
- State encodings (ArbIdle, ArbAccI, ArbAccD, ArbRespI, ArbRespD) and ArbStateWidth go into define.v alongside the existing constants.
- No sub-module. The request/response registers may reuse utilities/dffe.

Test Plan:
- Single fetch, MemLatency=1:
  - Stimulus: i_req=1, i_addr=0x00000004, memory word 0x34010001.
  - Response: mem_ce high for cycle 1 only, i_ready=1 and i_rdata=0x34010001 in cycle 2, stall_req high in cycles 0-1.
- Simultaneous requests:
  - Stimulus: i_req=1 at 0x8 and d_re=1 at 0x100 in the same cycle.
  - Response: data served first (d_ready in cycle 2), then fetch (i_ready in cycle 5). mem_addr shows 0x100 then 0x8.
- Byte write, MemLatency=3:
  - Stimulus: d_we=1, d_addr=0x20, d_byte_slct=4'b0010, d_wdata=0x0000AB00.
  - Response: mem_we=1 for cycles 1-3, d_ready in cycle 4. A following read of 0x20 shows only byte 1 changed to 0xAB.
- Operand change mid-access:
  - Stimulus: change d_addr from 0x40 to 0x80 during ACC_D.
  - Response: mem_addr stays 0x40 for the whole access.
- Reset mid-write:
  - Stimulus: rst=1 in the second cycle of a MemLatency=3 write.
  - Response: mem_ce and mem_we are 0 in the next cycle and d_ready never pulses. Fetches resume normally after rst drops.
- SOPC regression:
  - Stimulus: SOPC arithmetic program through the arbiter with MemLatency=2.
  - Response: final register file matches the MemLatency-free run.
